// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default VGA timing, colour mode type and frame total helpers
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic {
        MODE_RGB332 = 1'b0,
        MODE_GRAY   = 1'b1
    } mode_e;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel/line counters, region decode and IDLE/RUN scan control
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int VW       = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          mode,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          running,
    output logic          frame_wrap,
    output logic          active,
    output logic          hsync_act,
    output logic          vsync_act,
    output logic          frame_start,
    output logic          mode_sel
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic          state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          frame_start_q, frame_start_d;
    mode_e         mode_q, mode_d;
    logic          h_wrap, v_wrap, start;
    int            h_val, v_val;

    always_comb begin
        h_val      = int'(h_cnt_q);
        v_val      = int'(v_cnt_q);
        h_wrap     = (h_val == H_TOTAL - 1);
        v_wrap     = (v_val == V_TOTAL - 1);
        frame_wrap = (state_q == ST_RUN) && h_wrap && v_wrap;
        // enable and mode only matter where a frame could begin
        start      = enable && ((state_q == ST_IDLE) || frame_wrap);

        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_start_d = start;
        mode_d        = start ? mode_e'(mode) : mode_q;

        if (state_q == ST_IDLE) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (enable) begin
                state_d = ST_RUN;
            end
        end else begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
            if (frame_wrap && !enable) begin
                state_d = ST_IDLE;
            end
        end

        running   = (state_q == ST_RUN);
        active    = running && (h_val < H_ACTIVE) && (v_val < V_ACTIVE);
        hsync_act = running && (h_val >= H_ACTIVE + H_FP) && (h_val < H_ACTIVE + H_FP + H_SYNC);
        vsync_act = running && (v_val >= V_ACTIVE + V_FP) && (v_val < V_ACTIVE + V_FP + V_SYNC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
            mode_q        <= MODE_RGB332;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
            mode_q        <= mode_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign frame_start = frame_start_q;
    assign mode_sel    = mode_q;

endmodule

// File: rtl/vga_scaled_timing_ctrl.sv
// rtl/vga_scaled_timing_ctrl.sv - scaled framebuffer VGA scan-out: address generation,
// read-latency alignment and registered colour decode
module vga_scaled_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int SCALE_SHIFT = 1,
    parameter int RD_LAT      = 1,
    parameter int ADDR_W      = 18,
    parameter int COLOR_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               mode,
    output logic [ADDR_W-1:0]  VRAM_addr,
    input  logic [7:0]         VRAM_data,
    output logic               VGA_hsync,
    output logic               VGA_vsync,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               frame_start
);

    localparam int HW    = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW    = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int FB_W  = H_ACTIVE >> SCALE_SHIFT;
    localparam int SMASK = (1 << SCALE_SHIFT) - 1;
    localparam int DL    = RD_LAT + 1;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          running, frame_wrap, active, hsync_act, vsync_act, mode_sel;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk),
        .rst         (reset),
        .enable      (enable),
        .mode        (mode),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .running     (running),
        .frame_wrap  (frame_wrap),
        .active      (active),
        .hsync_act   (hsync_act),
        .vsync_act   (vsync_act),
        .frame_start (frame_start),
        .mode_sel    (mode_sel)
    );

    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         pipe_q [DL];
    logic [3:0]         pipe_d [DL];
    logic [3:0]         tail;
    logic [3:0]         r332, g332, b332;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;

    // Row base steps once per replicated group of lines, after its last line
    always_comb begin
        row_base_d = row_base_q;
        if (!running || frame_wrap) begin
            row_base_d = '0;
        end else if ((int'(h_cnt) == H_ACTIVE - 1) && (int'(v_cnt) < V_ACTIVE) &&
                     ((int'(v_cnt) & SMASK) == SMASK)) begin
            row_base_d = row_base_q + ADDR_W'(FB_W);
        end
        addr_d = active ? row_base_q + ADDR_W'(int'(h_cnt) >> SCALE_SHIFT) : '0;
    end

    // {mode, vsync, hsync, active} travel alongside the VRAM read
    always_comb begin
        pipe_d[0] = {mode_sel, vsync_act, hsync_act, active};
        for (int i = 1; i < DL; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        tail = pipe_q[DL-1];
        r332 = {VRAM_data[7:5], VRAM_data[7]};
        g332 = {VRAM_data[4:2], VRAM_data[4]};
        b332 = {VRAM_data[1:0], VRAM_data[1:0]};
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        // Source bits are repeated MSB-first so any COLOR_W truncates or extends cleanly
        for (int i = 0; i < COLOR_W; i++) begin
            if (tail[3]) begin
                r_d[COLOR_W-1-i] = VRAM_data[3'(7 - (i % 8))];
                g_d[COLOR_W-1-i] = VRAM_data[3'(7 - (i % 8))];
                b_d[COLOR_W-1-i] = VRAM_data[3'(7 - (i % 8))];
            end else begin
                r_d[COLOR_W-1-i] = r332[2'(3 - (i % 4))];
                g_d[COLOR_W-1-i] = g332[2'(3 - (i % 4))];
                b_d[COLOR_W-1-i] = b332[2'(3 - (i % 4))];
            end
        end
        if (!tail[0]) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
        hsync_d = tail[1] ? HS_POL : ~HS_POL;
        vsync_d = tail[2] ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base_q <= '0;
            addr_q     <= '0;
            for (int i = 0; i < DL; i++) begin
                pipe_q[i] <= '0;
            end
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            hsync_q    <= ~HS_POL;
            vsync_q    <= ~VS_POL;
        end else begin
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            pipe_q     <= pipe_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign VRAM_addr = addr_q;
    assign VGA_R     = r_q;
    assign VGA_G     = g_q;
    assign VGA_B     = b_q;
    assign VGA_hsync = hsync_q;
    assign VGA_vsync = vsync_q;

endmodule
